fib_stream_checker: RTL

Downstream consumer of the single- and double-rate Fibonacci generators. It accepts one or two 16-bit terms per cycle and checks the seed pair and the recurrence F(n) = F(n-1) + F(n-2), using modulo-2^W arithmetic. It reports the index of the first mismatch, flags arithmetic overflow, and signals completion after a programmed number of terms. It serves as a self-checking sink in benches and as a run-time monitor behind either generator.

---
 rtl/fib_stream_checker_if.sv | 25 ++
 rtl/fib_stream_checker.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fib_stream_checker_if.sv
// rtl/fib_stream_checker_if.sv - term stream bundle between a Fibonacci generator and the checker
interface fib_stream_checker_if #(
  parameter int W = 16
);
  logic         in_vld;
  logic         in_dbl;
  logic [W-1:0] num;
  logic [W-1:0] num2;

  // Generator side drives the lanes
  modport master (
    output in_vld,
    output in_dbl,
    output num,
    output num2
  );

  // Checker side consumes the lanes
  modport slave (
    input in_vld,
    input in_dbl,
    input num,
    input num2
  );
endinterface

// File: rtl/fib_stream_checker.sv
// rtl/fib_stream_checker.sv - single/double-rate Fibonacci stream checker with error and overflow capture
module fib_stream_checker #(
  parameter int W       = 16,
  parameter int N_TERMS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  fib_stream_checker_if.slave  in_if,
  output logic [W-1:0]         term_cnt,
  output logic                 err,
  output logic [W-1:0]         err_index,
  output logic                 ovf,
  output logic [W-1:0]         ovf_index,
  output logic                 done
);

  typedef enum logic [1:0] {
    SEED0 = 2'd0,
    SEED1 = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  // Everything a single term can change, so two lanes can be chained.
  typedef struct packed {
    state_t       st;
    logic [W-1:0] p1;
    logic [W-1:0] p2;
    logic         ovf;
    logic [W-1:0] ovf_idx;
    logic         err;
    logic [W-1:0] err_idx;
  } chk_t;

  state_t       state;
  logic [W-1:0] p1;
  logic [W-1:0] p2;

  chk_t         cur;
  chk_t         after0;
  chk_t         after1;
  logic [1:0]   add;
  logic [W:0]   cnt_sum;
  logic [W-1:0] cnt_next;
  logic         done_next;

  // Advance the checker by one term t sitting at sequence position idx.
  function automatic chk_t step(input chk_t c, input logic [W-1:0] t, input logic [W-1:0] idx);
    chk_t     n;
    logic [W:0] s;
    n = c;
    s = {1'b0, c.p2} + {1'b0, c.p1};
    case (c.st)
      SEED0: begin
        if (t == W'(1)) begin
          n.p1 = t;
          n.st = SEED1;
        end else begin
          n.st      = FAIL;
          n.err     = 1'b1;
          n.err_idx = idx;
        end
      end
      SEED1: begin
        if (t == W'(1)) begin
          n.p2 = c.p1;
          n.p1 = t;
          n.st = CHECK;
        end else begin
          n.st      = FAIL;
          n.err     = 1'b1;
          n.err_idx = idx;
        end
      end
      CHECK: begin
        // Carry-out is only reported; comparison uses the wrapped sum.
        if (s[W] && !c.ovf) begin
          n.ovf     = 1'b1;
          n.ovf_idx = idx;
        end
        if (t != s[W-1:0]) begin
          n.st      = FAIL;
          n.err     = 1'b1;
          n.err_idx = idx;
        end else begin
          n.p2 = c.p1;
          n.p1 = t;
        end
      end
      default: begin
        // FAIL absorbs: no further comparisons once the first error is held.
      end
    endcase
    return n;
  endfunction

  // Lane 0 then lane 1 through two chained checker stages, plus saturating count.
  always_comb begin
    cur = '{st: state, p1: p1, p2: p2, ovf: ovf, ovf_idx: ovf_index,
            err: err, err_idx: err_index};
    after0 = cur;
    if (in_if.in_vld) begin
      after0 = step(cur, in_if.num, term_cnt);
    end
    after1 = after0;
    if (in_if.in_vld && in_if.in_dbl) begin
      after1 = step(after0, in_if.num2, term_cnt + W'(1));
    end

    add = 2'd0;
    if (in_if.in_vld) begin
      add = in_if.in_dbl ? 2'd2 : 2'd1;
    end
    cnt_sum   = {1'b0, term_cnt} + {{(W-1){1'b0}}, add};
    cnt_next  = cnt_sum[W] ? {W{1'b1}} : cnt_sum[W-1:0];
    done_next = done | (cnt_next >= W'(N_TERMS));
  end

  // Checker FSM and all registered outputs; clr behaves exactly like reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEED0;
      p1        <= '0;
      p2        <= '0;
      term_cnt  <= '0;
      err       <= 1'b0;
      err_index <= '0;
      ovf       <= 1'b0;
      ovf_index <= '0;
      done      <= 1'b0;
    end else if (clr) begin
      state     <= SEED0;
      p1        <= '0;
      p2        <= '0;
      term_cnt  <= '0;
      err       <= 1'b0;
      err_index <= '0;
      ovf       <= 1'b0;
      ovf_index <= '0;
      done      <= 1'b0;
    end else begin
      state     <= after1.st;
      p1        <= after1.p1;
      p2        <= after1.p2;
      term_cnt  <= cnt_next;
      err       <= after1.err;
      err_index <= after1.err_idx;
      ovf       <= after1.ovf;
      ovf_index <= after1.ovf_idx;
      done      <= done_next;
    end
  end

endmodule
